// File: rtl/risc_pack.sv
// Shared Qrisc32 pipeline types: the decoded instruction payload and execute-stage helpers.
package risc_pack;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_AW     = 5;
    localparam int unsigned FLAG_Z_BIT = 1;
    localparam int unsigned FLAG_C_BIT = 0;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } ex_state_t;

    typedef struct packed {
        logic [XLEN-1:0]   val_r1;
        logic [XLEN-1:0]   val_r2;
        logic [XLEN-1:0]   val_dst;
        logic [REG_AW-1:0] src_r1;
        logic [REG_AW-1:0] src_r2;
        logic [REG_AW-1:0] dst_r;
        logic              write_reg;
        logic              read_mem;
        logic              write_mem;
        logic              and_op;
        logic              or_op;
        logic              xor_op;
        logic              add_op;
        logic              mul_op;
        logic              shl_op;
        logic              shr_op;
        logic              cmp_op;
        logic              ldrf_op;
        logic              jmpunc;
        logic              jmpz;
        logic              jmpnz;
        logic              jmpc;
        logic              jmpnc;
        logic              incr_r2_enable;
        logic [3:0]        incr_r2;
    } pipe_struct_t;

    // Post-increment step for the r2 pointer register.
    function automatic logic signed [XLEN-1:0] incr_delta(input logic [2:0] code);
        case (code)
            3'b001:  incr_delta = 32'sd1;
            3'b010:  incr_delta = 32'sd2;
            3'b011:  incr_delta = 32'sd4;
            3'b101:  incr_delta = -32'sd1;
            3'b110:  incr_delta = -32'sd2;
            3'b111:  incr_delta = -32'sd4;
            default: incr_delta = 32'sd0;
        endcase
    endfunction

endpackage

// File: rtl/qrisc32_ex_stage_mul_iter.sv
// Iterative shift-add multiplier; the first chunk of multiplier bits is folded in on the start edge.
module qrisc32_mul_iter
    import risc_pack::*;
#(
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [63:0]     prod
);

    localparam int unsigned BITS  = XLEN / MUL_CYCLES;
    localparam int unsigned CNT_W = $clog2(MUL_CYCLES + 1);

    logic [63:0]      acc_q, acc_d;
    logic [63:0]      mcand_q, mcand_d;
    logic [XLEN-1:0]  mplier_q, mplier_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             active_q, active_d;
    logic             done_q, done_d;

    logic [63:0]      op_a;
    logic [XLEN-1:0]  op_b;
    logic [63:0]      partial;

    always_comb begin : step
        op_a    = start ? {32'b0, a} : mcand_q;
        op_b    = start ? b : mplier_q;
        partial = '0;
        for (int unsigned i = 0; i < BITS; i++) begin
            if (op_b[i]) begin
                partial = partial + (op_a << i);
            end
        end

        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        rem_d    = rem_q;
        active_d = active_q;
        done_d   = done_q;

        if (start) begin
            acc_d    = partial;
            mcand_d  = op_a << BITS;
            mplier_d = op_b >> BITS;
            rem_d    = CNT_W'(MUL_CYCLES - 1);
            active_d = (MUL_CYCLES > 1);
            done_d   = (MUL_CYCLES == 1);
        end else if (active_q) begin
            acc_d    = acc_q + partial;
            mcand_d  = mcand_q << BITS;
            mplier_d = mplier_q >> BITS;
            rem_d    = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
                active_d = 1'b0;
                done_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            rem_q    <= rem_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign done = done_q;
    assign prod = acc_q;

endmodule

// File: rtl/qrisc32_ex_stage.sv
// Qrisc32 execute stage: ALU/shift/compare/address/jump evaluation, Z/C flags and output register.
module qrisc32_ex_stage
    import risc_pack::*;
#(
    parameter int unsigned MUL_CYCLES     = 4,
    parameter logic [1:0]  RESET_PC_FLAGS = 2'b00
) (
    input  logic            clk,
    input  logic            reset,
    input  pipe_struct_t    in_pipe,
    input  logic            in_valid,
    output logic            in_ready,
    output pipe_struct_t    out_pipe,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            jmp_taken,
    output logic [XLEN-1:0] jmp_pc,
    output logic            flag_z,
    output logic            flag_c
);

    localparam int unsigned CNT_W = $clog2(MUL_CYCLES + 1);

    ex_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    pipe_struct_t     mul_pipe_q, mul_pipe_d;
    pipe_struct_t     out_pipe_q, out_pipe_d;
    logic             out_valid_q, out_valid_d;
    logic             jmp_taken_q, jmp_taken_d;
    logic [XLEN-1:0]  jmp_pc_q, jmp_pc_d;
    logic [1:0]       flags_q, flags_d;

    logic             out_free;
    logic             accept;
    logic             mul_start_c;
    logic             mul_done;
    logic [63:0]      mul_prod;

    assign out_free = !out_valid_q || out_ready;
    assign in_ready = (state_q == IDLE) && out_free;
    assign accept   = in_valid && in_ready;

    qrisc32_mul_iter #(
        .MUL_CYCLES(MUL_CYCLES)
    ) u_mul (
        .clk  (clk),
        .reset(reset),
        .start(mul_start_c),
        .a    (in_pipe.val_r1),
        .b    (in_pipe.val_r2),
        .done (mul_done),
        .prod (mul_prod)
    );

    // Single-cycle evaluation of the incoming instruction against the current flags.
    pipe_struct_t    ex_pipe;
    logic [1:0]      ex_flags;
    logic            ex_jmp;
    logic [XLEN-1:0] r1, r2, diff, shl_res, shr_res;
    logic [4:0]      sh;
    logic [XLEN:0]   sum33;
    logic            shl_c, shr_c, cond;

    always_comb begin : exec
        ex_pipe  = in_pipe;
        ex_flags = flags_q;
        ex_jmp   = 1'b0;
        r1       = in_pipe.val_r1;
        r2       = in_pipe.val_r2;
        sh       = r2[4:0];
        sum33    = {1'b0, r1} + {1'b0, r2};
        diff     = r1 - r2;
        shl_res  = r1 << sh;
        shr_res  = r1 >> sh;
        shl_c    = (sh != 5'd0) && r1[5'(6'd32 - {1'b0, sh})];
        shr_c    = (sh != 5'd0) && r1[sh - 5'd1];
        cond     = (in_pipe.jmpz  &&  flags_q[FLAG_Z_BIT]) ||
                   (in_pipe.jmpnz && !flags_q[FLAG_Z_BIT]) ||
                   (in_pipe.jmpc  &&  flags_q[FLAG_C_BIT]) ||
                   (in_pipe.jmpnc && !flags_q[FLAG_C_BIT]);

        if (in_pipe.and_op || in_pipe.or_op || in_pipe.xor_op) begin
            ex_pipe.val_dst = in_pipe.and_op ? (r1 & r2) :
                              in_pipe.or_op  ? (r1 | r2) : (r1 ^ r2);
            ex_flags[FLAG_Z_BIT] = (ex_pipe.val_dst == '0);
        end else if (in_pipe.add_op) begin
            ex_pipe.val_dst      = sum33[XLEN-1:0];
            ex_flags[FLAG_C_BIT] = sum33[XLEN];
            ex_flags[FLAG_Z_BIT] = (sum33[XLEN-1:0] == '0);
        end else if (in_pipe.shl_op) begin
            ex_pipe.val_dst      = shl_res;
            ex_flags[FLAG_C_BIT] = shl_c;
        end else if (in_pipe.shr_op) begin
            ex_pipe.val_dst      = shr_res;
            ex_flags[FLAG_C_BIT] = shr_c;
        end else if (in_pipe.cmp_op) begin
            ex_pipe.write_reg    = 1'b0;
            ex_flags[FLAG_Z_BIT] = (diff == '0);
            ex_flags[FLAG_C_BIT] = (r1 < r2);
        end else if (in_pipe.ldrf_op) begin
            ex_pipe.val_dst = cond ? r1 : r2;
        end else if (in_pipe.read_mem || in_pipe.write_mem) begin
            ex_pipe.val_r1 = sum33[XLEN-1:0];
        end else begin
            ex_jmp = in_pipe.jmpunc || cond;
        end

        if (in_pipe.incr_r2_enable) begin
            ex_pipe.val_r2 = r2 + XLEN'(incr_delta(in_pipe.incr_r2[2:0]));
        end
    end

    // Completion view of the parked MUL instruction.
    pipe_struct_t mul_res_pipe;
    logic [1:0]   mul_flags;

    always_comb begin : mul_result
        mul_res_pipe         = mul_pipe_q;
        mul_res_pipe.val_dst = mul_prod[XLEN-1:0];
        if (mul_pipe_q.incr_r2_enable) begin
            mul_res_pipe.val_r2 = mul_pipe_q.val_r2 + XLEN'(incr_delta(mul_pipe_q.incr_r2[2:0]));
        end
        mul_flags             = flags_q;
        mul_flags[FLAG_Z_BIT] = (mul_prod[XLEN-1:0] == '0);
        mul_flags[FLAG_C_BIT] = |mul_prod[63:32];
    end

    always_comb begin : fsm_next
        state_d     = state_q;
        cnt_d       = cnt_q;
        mul_pipe_d  = mul_pipe_q;
        out_pipe_d  = out_pipe_q;
        out_valid_d = out_valid_q && !out_ready;
        flags_d     = flags_q;
        jmp_taken_d = 1'b0;
        jmp_pc_d    = jmp_pc_q;
        mul_start_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_pipe.mul_op) begin
                        state_d     = MUL_BUSY;
                        cnt_d       = CNT_W'(MUL_CYCLES - 1);
                        mul_pipe_d  = in_pipe;
                        mul_start_c = 1'b1;
                    end else begin
                        out_pipe_d  = ex_pipe;
                        out_valid_d = 1'b1;
                        flags_d     = ex_flags;
                        if (ex_jmp) begin
                            jmp_taken_d = 1'b1;
                            jmp_pc_d    = sum33[XLEN-1:0];
                        end
                    end
                end
            end
            MUL_BUSY: begin
                // A result still stalled at the output keeps the product parked.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (mul_done && out_free) begin
                    out_pipe_d  = mul_res_pipe;
                    out_valid_d = 1'b1;
                    flags_d     = mul_flags;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mul_pipe_q  <= '0;
            out_pipe_q  <= '0;
            out_valid_q <= 1'b0;
            jmp_taken_q <= 1'b0;
            jmp_pc_q    <= '0;
            flags_q     <= RESET_PC_FLAGS;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mul_pipe_q  <= mul_pipe_d;
            out_pipe_q  <= out_pipe_d;
            out_valid_q <= out_valid_d;
            jmp_taken_q <= jmp_taken_d;
            jmp_pc_q    <= jmp_pc_d;
            flags_q     <= flags_d;
        end
    end

    assign out_pipe  = out_pipe_q;
    assign out_valid = out_valid_q;
    assign jmp_taken = jmp_taken_q;
    assign jmp_pc    = jmp_pc_q;
    assign flag_z    = flags_q[FLAG_Z_BIT];
    assign flag_c    = flags_q[FLAG_C_BIT];

endmodule

// File: tb/tb_qrisc32_ex_stage.sv
// Scoreboard bench for qrisc32_ex_stage: directed cases plus randomized traffic against a behavioural model.
module tb_qrisc32_ex_stage;
    import risc_pack::*;

    logic         clk = 1'b0;
    logic         reset;
    pipe_struct_t in_pipe;
    logic         in_valid;
    logic         in_ready;
    pipe_struct_t out_pipe;
    logic         out_valid;
    logic         out_ready;
    logic         jmp_taken;
    logic [31:0]  jmp_pc;
    logic         flag_z;
    logic         flag_c;

    always #5 clk = ~clk;

    qrisc32_ex_stage #(
        .MUL_CYCLES    (4),
        .RESET_PC_FLAGS(2'b00)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_pipe  (in_pipe),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_pipe (out_pipe),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .jmp_taken(jmp_taken),
        .jmp_pc   (jmp_pc),
        .flag_z   (flag_z),
        .flag_c   (flag_c)
    );

    typedef struct packed {
        pipe_struct_t p;
        logic [1:0]   f;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [1:0]  m_flags;
    logic        exp_jt;
    logic [31:0] exp_jpc;
    int          stall_cnt;
    int          rdy_mode = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int delta_of(input logic [2:0] c);
        case (c)
            3'd1: return 1;
            3'd2: return 2;
            3'd3: return 4;
            3'd5: return -1;
            3'd6: return -2;
            3'd7: return -4;
            default: return 0;
        endcase
    endfunction

    // Reference behaviour; f is {Z,C} before and after the instruction.
    function automatic void model(input pipe_struct_t p, inout logic [1:0] f,
                                  output pipe_struct_t o, output logic jt, output logic [31:0] jpc);
        logic [63:0] w;
        logic        z, c, cnd;
        logic [31:0] r1, r2;
        int          amt;
        z = f[1]; c = f[0];
        o = p; jt = 1'b0; jpc = '0;
        r1 = p.val_r1; r2 = p.val_r2;
        amt = int'(r2 % 32);
        cnd = (p.jmpz && z) || (p.jmpnz && !z) || (p.jmpc && c) || (p.jmpnc && !c);
        if (p.and_op)      begin o.val_dst = r1 & r2; z = (o.val_dst == 0); end
        else if (p.or_op)  begin o.val_dst = r1 | r2; z = (o.val_dst == 0); end
        else if (p.xor_op) begin o.val_dst = r1 ^ r2; z = (o.val_dst == 0); end
        else if (p.add_op) begin
            w = 64'(r1) + 64'(r2); o.val_dst = w[31:0]; c = w[32]; z = (w[31:0] == 0);
        end else if (p.mul_op) begin
            w = 64'(r1) * 64'(r2); o.val_dst = w[31:0]; c = (w[63:32] != 0); z = (w[31:0] == 0);
        end else if (p.shl_op) begin
            w = 64'(r1) << amt; o.val_dst = w[31:0]; c = (amt == 0) ? 1'b0 : w[32];
        end else if (p.shr_op) begin
            w = {r1, 32'b0} >> amt; o.val_dst = w[63:32]; c = (amt == 0) ? 1'b0 : w[31];
        end else if (p.cmp_op) begin
            z = (r1 == r2); c = (r1 < r2); o.write_reg = 1'b0;
        end else if (p.ldrf_op) begin
            o.val_dst = cnd ? r1 : r2;
        end else if (p.read_mem || p.write_mem) begin
            o.val_r1 = r1 + r2;
        end else if (p.jmpunc || p.jmpz || p.jmpnz || p.jmpc || p.jmpnc) begin
            jt = p.jmpunc || cnd; jpc = r1 + r2;
        end
        if (p.incr_r2_enable) o.val_r2 = r2 + 32'(delta_of(p.incr_r2[2:0]));
        f = {z, c};
    endfunction

    function automatic pipe_struct_t rand_instr();
        pipe_struct_t p;
        p = '0;
        p.val_r1 = $urandom;
        p.val_r2 = $urandom;
        case ($urandom_range(0, 3))
            0: p.val_r2 = 32'($urandom_range(0, 40));
            1: p.val_r2 = 32'd0 - p.val_r1;
            2: p.val_r1 = p.val_r2;
            default: ;
        endcase
        if ($urandom_range(0, 5) == 0) p.val_r1 = 32'($urandom_range(0, 3)) << 16;
        p.val_dst        = $urandom;
        p.src_r1         = 5'($urandom);
        p.src_r2         = 5'($urandom);
        p.dst_r          = 5'($urandom);
        p.write_reg      = 1'($urandom);
        p.incr_r2_enable = 1'($urandom);
        p.incr_r2        = 4'($urandom);
        case ($urandom_range(0, 12))
            0: p.and_op = 1'b1;
            1: p.or_op  = 1'b1;
            2: p.xor_op = 1'b1;
            3: p.add_op = 1'b1;
            4: p.mul_op = 1'b1;
            5: p.shl_op = 1'b1;
            6: p.shr_op = 1'b1;
            7: p.cmp_op = 1'b1;
            8: begin
                p.ldrf_op = 1'b1;
                case ($urandom_range(0, 3))
                    0: p.jmpz = 1'b1;
                    1: p.jmpnz = 1'b1;
                    2: p.jmpc = 1'b1;
                    default: p.jmpnc = 1'b1;
                endcase
            end
            9:  p.read_mem  = 1'b1;
            10: p.write_mem = 1'b1;
            11: case ($urandom_range(0, 4))
                    0: p.jmpunc = 1'b1;
                    1: p.jmpz = 1'b1;
                    2: p.jmpnz = 1'b1;
                    3: p.jmpc = 1'b1;
                    default: p.jmpnc = 1'b1;
                endcase
            default: ;
        endcase
        return p;
    endfunction

    // Output-side driver.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: pops on output handshakes, checks jump pulses, pushes expectations on accepts.
    exp_t         mon_e;
    pipe_struct_t mon_o;
    logic         mon_jt;
    logic [31:0]  mon_jpc;

    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            m_flags   = 2'b00;
            exp_jt    = 1'b0;
            exp_jpc   = '0;
            stall_cnt = 0;
        end else begin
            if (out_valid && out_ready) begin
                stall_cnt = 0;
                if (sb.size() == 0) begin
                    check("spurious_out", 160'(out_valid), 160'(0));
                end else begin
                    mon_e = sb.pop_front();
                    check("out_pipe", 160'(out_pipe), 160'(mon_e.p));
                    check("flags", 160'({flag_z, flag_c}), 160'(mon_e.f));
                end
            end else if (sb.size() != 0) begin
                stall_cnt++;
                if (stall_cnt > 200) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL out_timeout: no output for %0d cycles, %0d pending", stall_cnt, sb.size());
                    sb.delete();
                    stall_cnt = 0;
                end
            end
            if (jmp_taken || exp_jt) begin
                check("jmp_taken", 160'(jmp_taken), 160'(exp_jt));
                if (exp_jt) check("jmp_pc", 160'(jmp_pc), 160'(exp_jpc));
            end
            exp_jt = 1'b0;
            if (in_valid && in_ready) begin
                model(in_pipe, m_flags, mon_o, mon_jt, mon_jpc);
                mon_e.p = mon_o;
                mon_e.f = m_flags;
                sb.push_back(mon_e);
                exp_jt  = mon_jt;
                exp_jpc = mon_jpc;
            end
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Presents p from a posedge+1 slot and returns at posedge+1 after its accept edge.
    task automatic issue(input pipe_struct_t p);
        bit got;
        got = 1'b0;
        in_pipe  = p;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL issue_timeout: in_ready never asserted");
        end
        align();
        in_valid = 1'b0;
    endtask

    function automatic pipe_struct_t mk(input int op, input logic [31:0] a, input logic [31:0] b);
        pipe_struct_t p;
        p = '0;
        p.val_r1 = a;
        p.val_r2 = b;
        p.val_dst = 32'hDEAD_BEEF;
        p.write_reg = 1'b1;
        p.dst_r = 5'd3;
        case (op)
            0: p.add_op = 1'b1;
            1: p.mul_op = 1'b1;
            2: p.cmp_op = 1'b1;
            3: p.jmpc = 1'b1;
            4: p.shl_op = 1'b1;
            5: p.shr_op = 1'b1;
            default: p.read_mem = 1'b1;
        endcase
        return p;
    endfunction

    initial begin
        pipe_struct_t p;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_pipe   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 160'(out_valid), 160'(0));
        check("rst_out_pipe", 160'(out_pipe), 160'(0));
        check("rst_jmp", 160'({jmp_taken, jmp_pc}), 160'(0));
        check("rst_flags", 160'({flag_z, flag_c}), 160'(2'b00));
        check("rst_in_ready", 160'(in_ready), 160'(1));
        align();
        reset = 1'b0;
        align();

        issue(mk(0, 32'hFFFF_FFFF, 32'd1));
        @(negedge clk);
        check("add_wrap", 160'({out_valid, out_pipe.val_dst, flag_z, flag_c}), 160'({1'b1, 32'd0, 1'b1, 1'b1}));
        align();

        issue(mk(1, 32'h0001_0000, 32'h0001_0000));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mul_busy_in_ready", 160'({in_ready, out_valid}), 160'(0));
        end
        @(negedge clk);
        check("mul_result", 160'({out_valid, out_pipe.val_dst, flag_z, flag_c}), 160'({1'b1, 32'd0, 1'b1, 1'b1}));
        align();

        issue(mk(2, 32'd5, 32'd7));
        @(negedge clk);
        check("cmp", 160'({out_pipe.write_reg, out_pipe.val_dst, flag_z, flag_c}), 160'({1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1}));
        align();
        issue(mk(3, 32'h100, 32'h20));
        @(negedge clk);
        check("jmpc", 160'({jmp_taken, jmp_pc}), 160'({1'b1, 32'h120}));
        align();

        issue(mk(4, 32'h8000_0001, 32'd1));
        @(negedge clk);
        check("shl", 160'({out_pipe.val_dst, flag_c}), 160'({32'h2, 1'b1}));
        align();
        issue(mk(5, 32'h8000_0001, 32'd1));
        @(negedge clk);
        check("shr", 160'({out_pipe.val_dst, flag_c}), 160'({32'h4000_0000, 1'b1}));
        align();
        issue(mk(4, 32'h8000_0001, 32'h20));
        @(negedge clk);
        check("shl_zero", 160'({out_pipe.val_dst, flag_c}), 160'({32'h8000_0001, 1'b0}));
        align();

        p = mk(6, 32'h40, 32'h10);
        p.incr_r2_enable = 1'b1;
        p.incr_r2 = 4'b0111;
        issue(p);
        @(negedge clk);
        check("ldrp", 160'({out_pipe.val_r1, out_pipe.val_r2}), 160'({32'h50, 32'h0C}));
        align();

        // Backpressure: first result must hold while the second waits.
        rdy_mode = 2;
        align();
        issue(mk(0, 32'd1, 32'd2));
        in_pipe  = mk(0, 32'd10, 32'd20);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold", 160'({in_ready, out_valid, out_pipe.val_dst}), 160'({1'b0, 1'b1, 32'd3}));
        end
        rdy_mode = 0;
        align();
        issue(mk(0, 32'd10, 32'd20));
        @(negedge clk);
        check("bp_second", 160'({out_valid, out_pipe.val_dst}), 160'({1'b1, 32'd30}));
        align();

        rdy_mode = 1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) align();
            issue(rand_instr());
        end
        rdy_mode = 0;
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        check("drain_empty", 160'(sb.size()), 160'(0));
        align();

        // Reset in the middle of a multiply.
        issue(mk(0, 32'hFFFF_FFFF, 32'd2));
        @(negedge clk);
        check("pre_rst_flags", 160'({flag_z, flag_c}), 160'(2'b01));
        align();
        issue(mk(1, 32'd3, 32'd5));
        @(negedge clk);
        align();
        reset = 1'b1;
        align();
        reset = 1'b0;
        @(negedge clk);
        check("midmul_rst", 160'({out_valid, flag_z, flag_c, in_ready, jmp_taken}), 160'({1'b0, 2'b00, 1'b1, 1'b0}));
        repeat (6) @(negedge clk);
        check("midmul_no_out", 160'(out_valid), 160'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
